// File: rtl/atom_sched.sv
// Stateful predicated add/sub atom shared by DEPTH slots, one output register stage,
// shadow/active configuration swapped atomically after in-flight work drains.
module atom_sched #(
  parameter int DEPTH = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i__cfg_valid,
  input  logic [2:0]       i__cfg_addr,
  input  logic [31:0]      i__cfg_data,
  input  logic             i__cfg_commit,
  output logic             o__cfg_busy,
  input  logic             i__pkt_valid,
  output logic             o__pkt_ready,
  input  logic [31:0]      i__pkt_1,
  input  logic [31:0]      i__pkt_2,
  input  logic [IDX_W-1:0] i__idx,
  output logic             o__out_valid,
  input  logic             i__out_ready,
  output logic [IDX_W-1:0] o__idx,
  output logic [31:0]      o__read,
  output logic [31:0]      o__write
);

  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, SWAP = 2'd2} mode_t;
  mode_t mode, mode_nxt;

  logic [31:0]      slot [DEPTH];
  logic [31:0]      sh_cons [5];
  logic [31:0]      act_cons [5];
  logic [16:0]      sh_ctrl, act_ctrl;
  logic             req_vld;
  logic [IDX_W-1:0] req_idx;
  logic [31:0]      req_p1, req_p2;
  logic             cfg_we, swap_en, in_hs, out_hs;
  logic [31:0]      cur, lhs, rhs, base, opa, opb, result;
  logic             guard, add;

  function automatic logic [31:0] operand(input logic [31:0] c, input logic [1:0] v,
                                          input logic [31:0] p1, input logic [31:0] p2);
    case (v)
      2'd0:    operand = p1;
      2'd1:    operand = p2;
      default: operand = c;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mode <= RUN;
    else     mode <= mode_nxt;
  end

  // A held request keeps draining in DRAIN; only new acceptance is blocked.
  always_comb begin
    mode_nxt     = mode;
    o__pkt_ready = 1'b0;
    cfg_we       = i__cfg_valid;
    swap_en      = 1'b0;
    case (mode)
      RUN: begin
        o__pkt_ready = !req_vld || i__out_ready;
        if (i__cfg_commit) mode_nxt = DRAIN;
      end
      DRAIN: begin
        if (!req_vld) mode_nxt = SWAP;
      end
      SWAP: begin
        cfg_we   = 1'b0;
        swap_en  = 1'b1;
        mode_nxt = RUN;
      end
      default: mode_nxt = RUN;
    endcase
  end

  assign o__cfg_busy = (mode != RUN);
  assign in_hs       = i__pkt_valid && o__pkt_ready;
  assign out_hs      = req_vld && i__out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 5; i++) begin
        sh_cons[i]  <= '0;
        act_cons[i] <= '0;
      end
      sh_ctrl  <= '0;
      act_ctrl <= '0;
    end else begin
      if (cfg_we) begin
        if (i__cfg_addr <= 3'd4)      sh_cons[i__cfg_addr] <= i__cfg_data;
        else if (i__cfg_addr == 3'd5) sh_ctrl <= i__cfg_data[16:0];
      end
      if (swap_en) begin
        for (int i = 0; i < 5; i++) act_cons[i] <= sh_cons[i];
        act_ctrl <= sh_ctrl;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_vld <= 1'b0;
      req_idx <= '0;
      req_p1  <= '0;
      req_p2  <= '0;
    end else if (in_hs) begin
      req_vld <= 1'b1;
      req_idx <= i__idx;
      req_p1  <= i__pkt_1;
      req_p2  <= i__pkt_2;
    end else if (out_hs) begin
      req_vld <= 1'b0;
    end
  end

  // Write-back lands on the same edge a follow-on request is captured, so it reads fresh state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) slot[i] <= '0;
    end else if (out_hs) begin
      slot[req_idx] <= result;
    end
  end

  always_comb begin
    cur   = slot[req_idx];
    lhs   = act_ctrl[0] ? 32'd0 : cur;
    rhs   = operand(act_cons[0], act_ctrl[2:1], req_p1, req_p2);
    guard = 1'b0;
    case (act_ctrl[14:13])
      2'd0:    guard = (lhs != rhs);
      2'd1:    guard = (lhs < rhs);
      2'd2:    guard = (lhs > rhs);
      default: guard = (lhs == rhs);
    endcase
    base = cur;
    opa  = '0;
    opb  = '0;
    add  = 1'b0;
    if (guard) begin
      base = act_ctrl[3] ? 32'd0 : cur;
      opa  = operand(act_cons[1], act_ctrl[5:4], req_p1, req_p2);
      opb  = operand(act_cons[3], act_ctrl[10:9], req_p1, req_p2);
      add  = act_ctrl[15];
    end else begin
      base = act_ctrl[6] ? 32'd0 : cur;
      opa  = operand(act_cons[2], act_ctrl[8:7], req_p1, req_p2);
      opb  = operand(act_cons[4], act_ctrl[12:11], req_p1, req_p2);
      add  = act_ctrl[16];
    end
    result = add ? (base + opa + opb) : (base + opa - opb);
  end

  assign o__out_valid = req_vld;
  assign o__idx       = req_idx;
  assign o__read      = cur;
  assign o__write     = result;

endmodule

// File: doc/atom_sched.md
Name: atom_sched

Overview:
- Sequencer and configurator for one stateful predicated add/sub ALU atom.
- The single atom datapath is shared by DEPTH state slots: each accepted packet selects a slot, the atom updates that slot, and the result goes downstream.
- Atom configuration is loaded through a shadow register bank. A commit state machine drains in-flight work, then swaps shadow to active atomically.
- Sits between packet parser (upstream) and egress/metadata stage (downstream).

Parameters:
DEPTH, 8, number of 32-bit state slots
IDX_W, 3, slot index width (log2 DEPTH)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
i__cfg_valid  in  1  shadow config write strobe
i__cfg_addr  in  3  0-4 = cons_1..cons_5, 5 = control word, 6-7 ignored
i__cfg_data  in  32  config write data
i__cfg_commit  in  1  request shadow->active swap (pulse)
o__cfg_busy  out  1  commit pending/in progress
i__pkt_valid  in  1  packet request valid
o__pkt_ready  out  1  packet request ready
i__pkt_1  in  32  packet field 1
i__pkt_2  in  32  packet field 2
i__idx  in  IDX_W  state slot index
o__out_valid  out  1  result valid
i__out_ready  in  1  downstream ready
o__idx  out  IDX_W  slot of result
o__read  out  32  slot value before update
o__write  out  32  slot value after update

Behaviour:
- Control word bits: [0] sel_1, [2:1] sel_2, [3] sel_3, [5:4] sel_4, [6] sel_5, [8:7] sel_6, [10:9] sel_7, [12:11] sel_8, [14:13] rel_opcode, [15] arith_opcode1, [16] arith_opcode2, [31:17] ignored.
- Atom function, all 32-bit, wrap modulo 2^32, unsigned compare:
  - mux2(s,b) = b ? 0 : s.
  - mux3(c,v) = pkt_1 for v=0, pkt_2 for v=1, c for v=2/3.
  - rel: 0 !=, 1 <, 2 >, 3 ==.
  - arith: 0 subtract, 1 add.
  - guard = rel(mux2(S,sel_1), mux3(cons_1,sel_2), rel_opcode).
  - If guard: write = mux2(S,sel_3) + arith(mux3(cons_2,sel_4), mux3(cons_4,sel_7), arith_opcode1).
  - Else: write = mux2(S,sel_5) + arith(mux3(cons_3,sel_6), mux3(cons_5,sel_8), arith_opcode2).
- Pipeline: one output register stage.
  - Handshake at edge t (valid&&ready) captures pkt/idx.
  - o__out_valid=1 from t+1; o__read=state[idx], o__write = f(state[idx], active cfg), both combinational off the held request.
  - state[idx] <= o__write only at the output handshake edge (o__out_valid && i__out_ready). A held stall never updates twice.
  - o__pkt_ready = (mode==RUN) && (!o__out_valid || i__out_ready), giving full throughput. Back-to-back requests to the same slot see the updated value, because write-back precedes the next read.
- Config writes go to the shadow bank only and are accepted in every state except SWAP. Writes in the SWAP cycle are dropped.
- FSM:
  - RUN: on i__cfg_commit -> DRAIN.
  - DRAIN: o__pkt_ready=0; stay while o__out_valid; when empty -> SWAP.
  - SWAP: active <= shadow (one cycle), -> RUN.
  - o__cfg_busy = (mode != RUN).
  - Commit while busy is ignored. A request stalled in DRAIN completes with the OLD config.
- A cfg write and commit in the same cycle: the write lands in the shadow bank before the swap.
- Reset (any time, including mid-transaction):
  - all state slots, shadow and active cfg, o__idx, o__read, o__write = 0.
  - o__out_valid=0, o__cfg_busy=0, mode=RUN.
  - The in-flight request is discarded with no write-back.
- All-zero config is a no-op: write = S + (pkt_1 - pkt_1) = S.

Test Plan:
- Counter: cons_2=cons_3=1, cons_4=cons_5=0, control=0x19520, commit. Then three requests idx=3 with i__out_ready=1 -> o__read 0,1,2 and o__write 1,2,3 on consecutive cycles; slot 5 read later = 0.
- Backpressure: counter config, one request idx=2, i__out_ready=0 for 4 cycles -> outputs held (read 0, write 1), o__pkt_ready=0. Release -> slot 2 = 1, not 4.
- Guarded max: control sel_1=0, sel_2=0, rel_opcode=1, sel_3=1, sel_4=0, sel_7=2, cons_4=0, arith_opcode1=1, sel_5=0, sel_6=2, sel_8=2, cons_3=cons_5=0. Send pkt_1 = 5, 3, 9 to idx 0 -> o__write = 5, 5, 9.
- Commit mid-stream: request stalled, then commit -> o__cfg_busy=1, o__pkt_ready=0. Stalled result uses the old config. SWAP occurs one cycle after the drain completes. The next request uses the new config.
- Commit-while-busy and cfg write in SWAP -> both dropped; the shadow bank keeps its prior value (verify by a second commit).
- Assert rst with o__out_valid=1 on idx=1 (counter) -> all outputs 0 immediately, slot 1 stays 0, config reverts to no-op.
